// File: rtl/mem_access_pkg.sv
// Package core: pipeline op classes plus memory-stage state, size types,
// byte-enable patterns and op predicates shared by mem_access and mem_align.
package core;

    typedef enum logic [3:0] {
        OP_NULL               = 4'd0,
        OP_REGISTER           = 4'd1,
        OP_JUMP_OR_BRANCH     = 4'd2,
        OP_LOAD_BYTE          = 4'd3,
        OP_LOAD_HALF          = 4'd4,
        OP_LOAD_WORD          = 4'd5,
        OP_LOAD_BYTE_UNSIGNED = 4'd6,
        OP_LOAD_HALF_UNSIGNED = 4'd7,
        OP_STORE_BYTE         = 4'd8,
        OP_STORE_HALF         = 4'd9,
        OP_STORE_WORD         = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } mem_size_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic is_load(input op_t op);
        return op inside {OP_LOAD_BYTE, OP_LOAD_HALF, OP_LOAD_WORD,
                          OP_LOAD_BYTE_UNSIGNED, OP_LOAD_HALF_UNSIGNED};
    endfunction

    function automatic logic is_store(input op_t op);
        return op inside {OP_STORE_BYTE, OP_STORE_HALF, OP_STORE_WORD};
    endfunction

    function automatic logic is_unsigned(input op_t op);
        return op inside {OP_LOAD_BYTE_UNSIGNED, OP_LOAD_HALF_UNSIGNED};
    endfunction

    function automatic mem_size_t op_size(input op_t op);
        case (op)
            OP_LOAD_BYTE, OP_LOAD_BYTE_UNSIGNED, OP_STORE_BYTE: return SZ_BYTE;
            OP_LOAD_HALF, OP_LOAD_HALF_UNSIGNED, OP_STORE_HALF: return SZ_HALF;
            OP_LOAD_WORD, OP_STORE_WORD:                        return SZ_WORD;
            default:                                            return SZ_NONE;
        endcase
    endfunction

    // Low address bits after truncation to the access's natural alignment.
    function automatic logic [1:0] align_offset(input op_t op, input logic [1:0] a);
        case (op_size(op))
            SZ_HALF: return {a[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return a;
        endcase
    endfunction

    function automatic logic is_misaligned(input op_t op, input logic [1:0] a);
        case (op_size(op))
            SZ_HALF: return a[0];
            SZ_WORD: return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: stateless store lane replication / byte-enable generation and
// load byte/half extraction with sign or zero extension.
module mem_align
    import core::*;
(
    input  op_t         st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  op_t         ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sext_s;

    // Store side: replicate the datum across lanes, enable only its bytes.
    always_comb begin
        st_be    = BE_NONE;
        st_wdata = st_data;
        case (op_size(st_op))
            SZ_BYTE: begin
                st_be    = BE_BYTE0 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_off[1] ? BE_HALF_HI : BE_HALF_LO;
                st_wdata = {2{st_data[15:0]}};
            end
            SZ_WORD: begin
                st_be    = BE_WORD;
                st_wdata = st_data;
            end
            default: begin
                st_be    = BE_NONE;
                st_wdata = st_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to 32 bits.
    always_comb begin
        byte_s = 8'h00;
        case (ld_off)
            2'd0:    byte_s = ld_rdata[7:0];
            2'd1:    byte_s = ld_rdata[15:8];
            2'd2:    byte_s = ld_rdata[23:16];
            2'd3:    byte_s = ld_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        half_s  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        sext_s  = !is_unsigned(ld_op);
        ld_data = ld_rdata;
        case (op_size(ld_op))
            SZ_BYTE: ld_data = {{24{sext_s & byte_s[7]}}, byte_s};
            SZ_HALF: ld_data = {{16{sext_s & half_s[15]}}, half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: rv32 memory stage FSM (IDLE/REQ/RESP) with bus timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating.
module mem_access
    import core::*;
#(
    parameter int unsigned BUS_TIMEOUT = 32'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        exc_misaligned,
    output logic        exc_bus
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT < 32'd1) ? 32'd1 : $clog2(BUS_TIMEOUT + 32'd1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(BUS_TIMEOUT);

    mem_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    op_t              op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_we_q, out_we_d;
    logic [4:0]       out_rd_q, out_rd_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             exc_mis_q, exc_mis_d;
    logic             exc_bus_q, exc_bus_d;

    logic [1:0]       in_off_s;
    logic             in_mem_s;
    logic             trap_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             tmo_hit_s;
    logic [3:0]       st_be_s;
    logic [31:0]      st_wdata_s;
    logic [31:0]      ld_data_s;

    assign in_off_s = align_offset(in_op, in_addr[1:0]);
    assign in_mem_s = is_load(in_op) | is_store(in_op);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_s = is_misaligned(in_op, in_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    mem_align u_align (
        .st_op    (in_op),
        .st_off   (in_off_s),
        .st_data  (in_wdata),
        .st_be    (st_be_s),
        .st_wdata (st_wdata_s),
        .ld_op    (op_q),
        .ld_off   (off_q),
        .ld_rdata (dmem_rdata),
        .ld_data  (ld_data_s)
    );

    // Saturating wait counter and timeout detect; BUS_TIMEOUT of 0 never fires.
    always_comb begin
        if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_W'(1);
        end
        tmo_hit_s = (BUS_TIMEOUT != 32'd0) && (cnt_inc_s == TMO);
    end

    // Next-state and output computation for the IDLE/REQ/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        rd_d        = rd_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_we_d    = out_we_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        exc_mis_d   = 1'b0;
        exc_bus_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && (in_op == OP_REGISTER || in_op == OP_JUMP_OR_BRANCH)) begin
                    out_valid_d = 1'b1;
                    out_we_d    = 1'b1;
                    out_rd_d    = in_rd;
                    out_data_d  = in_addr;
                end else if (in_valid && in_mem_s && trap_s) begin
                    exc_mis_d = 1'b1;
                end else if (in_valid && in_mem_s) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = is_store(in_op);
                    addr_d  = {in_addr[31:2], 2'b00};
                    be_d    = st_be_s;
                    wdata_d = st_wdata_s;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    off_d   = in_off_s;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // A same-cycle rvalid is ignored; only the grant is consumed here.
                if (dmem_gnt && we_q) begin
                    state_d     = IDLE;
                    req_d       = 1'b0;
                    out_valid_d = 1'b1;
                    out_we_d    = 1'b0;
                    out_rd_d    = rd_q;
                end else if (dmem_gnt) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end else if (tmo_hit_s) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_we_d    = 1'b1;
                    out_rd_d    = rd_q;
                    out_data_d  = ld_data_s;
                end else if (tmo_hit_s) begin
                    state_d   = IDLE;
                    exc_bus_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            op_q        <= OP_NULL;
            rd_q        <= 5'd0;
            off_q       <= 2'd0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_rd_q    <= 5'd0;
            out_data_q  <= 32'h0000_0000;
            exc_mis_q   <= 1'b0;
            exc_bus_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_we_q    <= out_we_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            exc_mis_q   <= exc_mis_d;
            exc_bus_q   <= exc_bus_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign dmem_req       = req_q;
    assign dmem_we        = we_q;
    assign dmem_addr      = addr_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign out_valid      = out_valid_q;
    assign out_we         = out_we_q;
    assign out_rd         = out_rd_q;
    assign out_data       = out_data_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus        = exc_bus_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus random ops against
// an arithmetic reference model of lane selection, byte enables and extension.
module tb_mem_access;
    import core::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid, out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        exc_misaligned, exc_bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access #(.BUS_TIMEOUT(32'd4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .exc_misaligned(exc_misaligned), .exc_bus(exc_bus)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(input op_t op);
        case (op)
            OP_LOAD_BYTE, OP_LOAD_BYTE_UNSIGNED, OP_STORE_BYTE: return 1;
            OP_LOAD_HALF, OP_LOAD_HALF_UNSIGNED, OP_STORE_HALF: return 2;
            OP_LOAD_WORD, OP_STORE_WORD:                        return 4;
            default:                                            return 0;
        endcase
    endfunction

    function automatic bit m_store(input op_t op);
        return (op == OP_STORE_BYTE) || (op == OP_STORE_HALF) || (op == OP_STORE_WORD);
    endfunction

    function automatic bit m_signed(input op_t op);
        return (op == OP_LOAD_BYTE) || (op == OP_LOAD_HALF);
    endfunction

    function automatic longint m_eff(input op_t op, input logic [31:0] a);
        longint la;
        la = a;
        return la - (la % m_size(op));
    endfunction

    function automatic logic [3:0] m_be(input op_t op, input logic [31:0] a);
        longint v;
        v = ((64'sd1 << m_size(op)) - 1) << (m_eff(op, a) % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input op_t op, input logic [31:0] d);
        longint ld, v;
        ld = d;
        if (m_size(op) == 1)      v = (ld % 256) * 64'h0101_0101;
        else if (m_size(op) == 2) v = (ld % 65536) * 64'h0001_0001;
        else                      v = ld;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input op_t op, input logic [31:0] a, input logic [31:0] r);
        longint w, v, span;
        int     bits;
        w    = r;
        bits = 8 * m_size(op);
        span = 64'sd1 << bits;
        v    = (w >> (8 * (m_eff(op, a) % 4))) % span;
        if (m_signed(op) && bits < 32 && v >= (span / 2)) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- one instruction through the stage ----------------
    task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] r);
        bit          is_mem, st, mis;
        logic [31:0] ea, ed;
        is_mem = (m_size(op) != 0);
        st     = m_store(op);
        mis    = is_mem && ((a % m_size(op)) != 0);
        ea     = {a[31:2], 2'b00};
        in_valid = 1'b1; in_op = op; in_addr = a; in_wdata = d; in_rd = rd;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_idle: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = OP_NULL;
        if (!is_mem) begin
            ed = (op == OP_NULL) ? 32'd0 : a;
            total++; if (out_valid !== (op != OP_NULL)) begin bad++; $display("FAIL alu_valid: got %b want %b", out_valid, op != OP_NULL); end
            if (op != OP_NULL) begin
                total++; if (out_data !== ed || out_we !== 1'b1 || out_rd !== rd) begin
                    bad++; $display("FAIL alu_result: got %h/%b/%0d want %h/1/%0d", out_data, out_we, out_rd, ed, rd); end
            end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL alu_ready: got %b want 1", in_ready); end
            return;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (mis) begin
            total++; if (exc_misaligned !== 1'b1 || dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL trap: got exc=%b req=%b ov=%b rdy=%b want 1 0 0 1", exc_misaligned, dmem_req, out_valid, in_ready); end
            @(posedge clk); #1;
            total++; if (exc_misaligned !== 1'b0) begin bad++; $display("FAIL trap_pulse: got %b want 0", exc_misaligned); end
            return;
        end
`endif
        total++; if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== ea || in_ready !== 1'b0) begin
            bad++; $display("FAIL req: got req=%b we=%b addr=%h rdy=%b want 1 %b %h 0", dmem_req, dmem_we, dmem_addr, in_ready, st, ea); end
        total++; if (dmem_be !== m_be(op, a)) begin bad++; $display("FAIL be: got %b want %b", dmem_be, m_be(op, a)); end
        if (st) begin
            total++; if (dmem_wdata !== m_wdata(op, d)) begin bad++; $display("FAIL wdata: got %h want %h", dmem_wdata, m_wdata(op, d)); end
        end
        for (int i = 0; i < gd; i++) begin
            @(posedge clk); #1;
            total++; if (dmem_req !== 1'b1 || dmem_addr !== ea || exc_bus !== 1'b0) begin
                bad++; $display("FAIL hold: got req=%b addr=%h bus=%b want 1 %h 0", dmem_req, dmem_addr, exc_bus, ea); end
        end
        dmem_gnt = 1'b1; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = ~r;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (st) begin
            total++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_rd !== rd || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL store_done: got ov=%b we=%b rd=%0d req=%b rdy=%b want 1 0 %0d 0 1", out_valid, out_we, out_rd, dmem_req, in_ready, rd); end
        end else begin
            total++; if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b0) begin
                bad++; $display("FAIL load_gnt: got ov=%b req=%b rdy=%b want 0 0 0", out_valid, dmem_req, in_ready); end
            repeat (rvd) @(posedge clk);
            #1; dmem_rvalid = 1'b1; dmem_rdata = r;
            @(posedge clk); #1;
            dmem_rvalid = 1'b0;
            ed = m_load(op, a, r);
            total++; if (out_valid !== 1'b1 || out_we !== 1'b1 || out_rd !== rd || out_data !== ed || in_ready !== 1'b1) begin
                bad++; $display("FAIL load_done: got ov=%b we=%b rd=%0d data=%h rdy=%b want 1 1 %0d %h 1", out_valid, out_we, out_rd, out_data, in_ready, rd, ed); end
        end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || exc_bus !== 1'b0 || exc_misaligned !== 1'b0) begin
            bad++; $display("FAIL pulse: got ov=%b bus=%b mis=%b want 0 0 0", out_valid, exc_bus, exc_misaligned); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_op = OP_NULL; in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #3;
        total++; if (dmem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || exc_bus !== 1'b0 || exc_misaligned !== 1'b0) begin
            bad++; $display("FAIL reset_ctl: got req=%b rdy=%b ov=%b bus=%b mis=%b", dmem_req, in_ready, out_valid, exc_bus, exc_misaligned); end
        total++; if (dmem_addr !== 32'd0 || dmem_be !== 4'd0 || dmem_wdata !== 32'd0 || out_data !== 32'd0 || out_we !== 1'b0) begin
            bad++; $display("FAIL reset_data: got addr=%h be=%b wd=%h od=%h we=%b want zeros", dmem_addr, dmem_be, dmem_wdata, out_data, out_we); end
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
    endtask

    task automatic test_register;
        run_op(OP_REGISTER, 32'h1234_5678, 32'd0, 5'd5, 0, 0, 32'd0);
        run_op(OP_NULL, 32'hDEAD_BEEF, 32'd0, 5'd9, 0, 0, 32'd0);
    endtask

    task automatic test_load;
        run_op(OP_LOAD_BYTE, 32'h0000_0103, 32'd0, 5'd3, 2, 1, 32'h80FF_0000);
        run_op(OP_LOAD_HALF_UNSIGNED, 32'h0000_0202, 32'd0, 5'd4, 0, 0, 32'hBEEF_1234);
        run_op(OP_LOAD_HALF, 32'h0000_0202, 32'd0, 5'd6, 1, 2, 32'hBEEF_1234);
        run_op(OP_LOAD_BYTE_UNSIGNED, 32'h0000_0101, 32'd0, 5'd7, 0, 3, 32'h1234_F678);
    endtask

    task automatic test_store;
        run_op(OP_STORE_BYTE, 32'h0000_0301, 32'h5555_55AB, 5'd8, 1, 0, 32'd0);
        run_op(OP_STORE_HALF, 32'h0000_0302, 32'h0000_C0DE, 5'd9, 3, 0, 32'd0);
        run_op(OP_STORE_WORD, 32'h0000_0300, 32'hCAFE_F00D, 5'd10, 0, 0, 32'd0);
    endtask

    task automatic test_misaligned;
        run_op(OP_LOAD_WORD, 32'h0000_0402, 32'd0, 5'd11, 0, 0, 32'hCAFE_F00D);
        run_op(OP_STORE_HALF, 32'h0000_0405, 32'h0000_1357, 5'd12, 0, 0, 32'd0);
    endtask

    task automatic test_timeout;
        in_valid = 1'b1; in_op = OP_LOAD_WORD; in_addr = 32'h0000_0500; in_rd = 5'd13;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (exc_bus !== 1'b0 || dmem_req !== 1'b1) begin bad++; $display("FAIL tmo_wait: got bus=%b req=%b want 0 1", exc_bus, dmem_req); end
        end
        @(posedge clk); #1;
        total++; if (exc_bus !== 1'b1 || dmem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL tmo_req: got bus=%b req=%b ov=%b rdy=%b want 1 0 0 1", exc_bus, dmem_req, out_valid, in_ready); end
        @(posedge clk); #1;
        total++; if (exc_bus !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", exc_bus); end
        // response phase timeout: grant at once, rvalid never arrives
        in_valid = 1'b1; in_op = OP_LOAD_WORD; in_addr = 32'h0000_0700;
        @(posedge clk); #1; in_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1; dmem_gnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (exc_bus !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL tmo_resp_wait: got bus=%b rdy=%b want 0 0", exc_bus, in_ready); end
        @(posedge clk); #1;
        total++; if (exc_bus !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_resp: got bus=%b rdy=%b ov=%b want 1 1 0", exc_bus, in_ready, out_valid); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1; dmem_rvalid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stray_rvalid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; in_op = OP_LOAD_WORD; in_addr = 32'h0000_0600; in_rd = 5'd14;
        @(posedge clk); #1; in_valid = 1'b0;
        total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rst_pre: got %b want 1", dmem_req); end
        #2; reset_n = 1'b0; #1;
        total++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid: got req=%b rdy=%b want 0 1", dmem_req, in_ready); end
        @(posedge clk); #1; reset_n = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_8888;
        @(posedge clk); #1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        total++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL rst_discard: got ov=%b req=%b want 0 0", out_valid, dmem_req); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = OP_JUMP_OR_BRANCH; in_addr = 32'h100 * i + 32'd7; in_rd = 5'(i + 20);
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== 32'h100 * i + 32'd7 || out_rd !== 5'(i + 20)) begin
                bad++; $display("FAIL b2b: got ov=%b data=%h rd=%0d want 1 %h %0d", out_valid, out_data, out_rd, 32'h100 * i + 32'd7, i + 20); end
        end
        in_valid = 1'b0; in_op = OP_NULL;
        run_op(OP_STORE_WORD, 32'h0000_0800, 32'hA5A5_5A5A, 5'd1, 0, 0, 32'd0);
        run_op(OP_LOAD_WORD, 32'h0000_0800, 32'd0, 5'd2, 0, 0, 32'hA5A5_5A5A);
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            run_op(op_t'(4'($urandom_range(0, 10))), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset;
        test_register;
        test_load;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
